// File: rtl/snake_pkg.sv
// Shared definitions for the snake game slice: coordinate widths, the
// heading encoding used by the navigation FSM, and body-controller states.
package snake_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned LEN_W = 6;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // Opposite headings differ only in bit 1 with this encoding.
  function automatic dir_e dir_reverse(input dir_e d);
    return dir_e'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/snake_body_ctrl_if.sv
// Bundle between the game top and the snake body controller.
//   master: drives EN, DIR, TARGET_X/Y, QUERY_X/Y; observes status outputs
//   slave : the body controller
interface snake_body_ctrl_if;
  import snake_pkg::*;

  logic             EN;
  logic [1:0]       DIR;
  logic [X_W-1:0]   TARGET_X;
  logic [Y_W-1:0]   TARGET_Y;
  logic [X_W-1:0]   QUERY_X;
  logic [Y_W-1:0]   QUERY_Y;
  logic [X_W-1:0]   HEAD_X;
  logic [Y_W-1:0]   HEAD_Y;
  logic [LEN_W-1:0] LENGTH;
  logic             MOVE_STB;
  logic             EATEN;
  logic             DEAD;
  logic             BODY_HIT;
  logic             HEAD_HIT;

  modport master (
    output EN, DIR, TARGET_X, TARGET_Y, QUERY_X, QUERY_Y,
    input  HEAD_X, HEAD_Y, LENGTH, MOVE_STB, EATEN, DEAD, BODY_HIT, HEAD_HIT
  );

  modport slave (
    input  EN, DIR, TARGET_X, TARGET_Y, QUERY_X, QUERY_Y,
    output HEAD_X, HEAD_Y, LENGTH, MOVE_STB, EATEN, DEAD, BODY_HIT, HEAD_HIT
  );
endinterface

// File: rtl/move_tick_gen.sv
// Move tick divider: counts 0..TICK_DIV-1 while RUN is high, pulses TICK
// combinationally on the terminal count and wraps. CLR forces the count to 0.
//   CLK, RESET (async, active-low), CLR, RUN -> TICK
module move_tick_gen #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLR,
  input  logic RUN,
  output logic TICK
);
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    TICK  = 1'b0;
    if (CLR) begin
      cnt_d = '0;
    end else if (RUN) begin
      if (cnt_q == CW'(TICK_DIV - 1)) begin
        cnt_d = '0;
        TICK  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller: advances the head one cell per move tick on a
// wrapping H_CELLS x V_CELLS grid, shifts the body, grows on target capture,
// detects self-collision and answers registered per-cell hit queries.
//   CLK, RESET (async, active-low)
//   bus (slave): EN, DIR, TARGET_X/Y, QUERY_X/Y in;
//                HEAD_X/Y, LENGTH, MOVE_STB, EATEN, DEAD, BODY_HIT, HEAD_HIT out
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned H_CELLS  = 160,
  parameter int unsigned V_CELLS  = 120,
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned INIT_LEN = 4,
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input logic              CLK,
  input logic              RESET,
  snake_body_ctrl_if.slave bus
);
  logic [X_W-1:0]   seg_x_q [MAX_LEN];
  logic [Y_W-1:0]   seg_y_q [MAX_LEN];
  logic [LEN_W-1:0] len_q, lim;
  dir_e             last_dir_q, dir_in, heading;
  state_e           state_q, state_d;
  logic             move_stb_q, eaten_q, body_hit_q, head_hit_q;
  logic             body_hit_d, head_hit_d;
  logic             tick, tick_clr, tick_run;
  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;
  logic             eat, coll, commit;

  assign tick_clr = (state_q == ST_IDLE) && bus.EN;
  assign tick_run = (state_q == ST_RUN) && bus.EN;

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (tick_clr),
    .RUN   (tick_run),
    .TICK  (tick)
  );

  // Heading selection and wrapped next-head cell.
  always_comb begin
    dir_in  = dir_e'(bus.DIR);
    heading = (dir_in == dir_reverse(last_dir_q)) ? last_dir_q : dir_in;
    nx      = seg_x_q[0];
    ny      = seg_y_q[0];
    case (heading)
      DIR_UP:    ny = (seg_y_q[0] == '0) ? Y_W'(V_CELLS - 1) : seg_y_q[0] - Y_W'(1);
      DIR_DOWN:  ny = (seg_y_q[0] == Y_W'(V_CELLS - 1)) ? '0 : seg_y_q[0] + Y_W'(1);
      DIR_LEFT:  nx = (seg_x_q[0] == '0) ? X_W'(H_CELLS - 1) : seg_x_q[0] - X_W'(1);
      DIR_RIGHT: nx = (seg_x_q[0] == X_W'(H_CELLS - 1)) ? '0 : seg_x_q[0] + X_W'(1);
      default: ;
    endcase
  end

  // Collision against live segments; the tail cell only counts when it stays (eat).
  always_comb begin
    eat  = (nx == bus.TARGET_X) && (ny == bus.TARGET_Y);
    lim  = eat ? len_q : len_q - LEN_W'(1);
    coll = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < lim) && (seg_x_q[i] == nx) && (seg_y_q[i] == ny)) coll = 1'b1;
    end
    commit = tick && !coll;
  end

  // Query against current (pre-shift) segments.
  always_comb begin
    head_hit_d = (seg_x_q[0] == bus.QUERY_X) && (seg_y_q[0] == bus.QUERY_Y);
    body_hit_d = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_q) && (seg_x_q[i] == bus.QUERY_X) && (seg_y_q[i] == bus.QUERY_Y))
        body_hit_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.EN) state_d = ST_RUN;
      ST_RUN:  if (tick && coll) state_d = ST_DEAD;
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? X_W'(H_CELLS / 2) : '0;
        seg_y_q[i] <= (i < INIT_LEN) ? Y_W'(V_CELLS / 2 + i) : '0;
      end
      len_q      <= LEN_W'(INIT_LEN);
      last_dir_q <= DIR_UP;
      move_stb_q <= 1'b0;
      eaten_q    <= 1'b0;
      body_hit_q <= 1'b0;
      head_hit_q <= 1'b0;
    end else begin
      move_stb_q <= commit;
      eaten_q    <= commit && eat;
      body_hit_q <= body_hit_d;
      head_hit_q <= head_hit_d;
      if (commit) begin
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          seg_x_q[i] <= seg_x_q[i-1];
          seg_y_q[i] <= seg_y_q[i-1];
        end
        seg_x_q[0] <= nx;
        seg_y_q[0] <= ny;
        last_dir_q <= heading;
        if (eat && (len_q < LEN_W'(MAX_LEN))) len_q <= len_q + LEN_W'(1);
      end
    end
  end

  assign bus.HEAD_X   = seg_x_q[0];
  assign bus.HEAD_Y   = seg_y_q[0];
  assign bus.LENGTH   = len_q;
  assign bus.MOVE_STB = move_stb_q;
  assign bus.EATEN    = eaten_q;
  assign bus.DEAD     = (state_q == ST_DEAD);
  assign bus.BODY_HIT = body_hit_q;
  assign bus.HEAD_HIT = head_hit_q;
endmodule
